// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory read bus between fetch unit and imem
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multi-cycle IF stage: PC, imem fetch FSM with timeout, IR, next-PC
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    fetch_start,
  input  logic                    pc_we,
  input  logic [1:0]              pc_src,
  input  logic [15:0]             imm16,
  input  logic [25:0]             addr26,
  input  logic [31:0]             jr_target,
  instr_fetch_unit_if.master      imem,
  output logic [31:0]             inst,
  output logic                    inst_valid,
  output logic [31:0]             pc,
  output logic [31:0]             pc_plus4,
  output logic                    busy,
  output logic                    fetch_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam int         CW     = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [31:0]   fetch_addr;
  logic [CW-1:0] cnt;
  logic [31:0]   next_pc;

  assign pc_plus4       = pc + 32'd4;
  assign busy           = (state == S_BUSY);
  assign inst_valid     = (state == S_HOLD);
  assign imem.imem_req  = (state == S_BUSY);
  // Address comes from the latched fetch PC so PC writes never disturb a fetch in flight.
  assign imem.imem_addr = fetch_addr;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      2'b10: next_pc = {pc_plus4[31:28], addr26, 2'b00};
      2'b11: next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= RESET_PC;
      inst       <= 32'd0;
      fetch_addr <= 32'd0;
      cnt        <= '0;
      state      <= S_IDLE;
      fetch_err  <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      if (pc_we)
        pc <= next_pc;
      case (state)
        S_IDLE, S_HOLD: begin
          if (fetch_start) begin
            if (pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= S_IDLE;
            end else begin
              fetch_addr <= pc;
              cnt        <= '0;
              state      <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // Ready wins even on the final allowed cycle.
          if (imem.imem_ready) begin
            inst  <= imem.imem_rdata;
            state <= S_HOLD;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            fetch_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_start;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] jr_target;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        fetch_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_inst;

  instr_fetch_unit_if imem_bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .fetch_start(fetch_start), .pc_we(pc_we), .pc_src(pc_src),
    .imm16(imm16), .addr26(addr26), .jr_target(jr_target), .imem(imem_bus),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
    .busy(busy), .fetch_err(fetch_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_we = 1'b1; pc_src = 2'b11; jr_target = v;
    tick;
    pc_we = 1'b0;
    n_cmp++; if (pc !== v) begin n_err++; $display("FAIL set_pc: pc=%h required %h", pc, v); end
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] addr, input logic [31:0] data, input int stall);
    logic [31:0] exp;
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    n_cmp++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== addr || busy !== 1'b1 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL %s_req: req=%b addr=%h busy=%b valid=%b required 1 %h 1 0", nm, imem_bus.imem_req, imem_bus.imem_addr, busy, inst_valid, addr);
    end
    for (int i = 0; i < stall; i++) tick;
    n_cmp++; if (busy !== 1'b1 || fetch_err !== 1'b0) begin
      n_err++; $display("FAIL %s_stall: busy=%b err=%b required 1 0", nm, busy, fetch_err);
    end
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = data;
    exp_q.push_back(data);
    tick;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    n_cmp++; if (inst_valid !== 1'b1 || busy !== 1'b0 || imem_bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL %s_done: valid=%b busy=%b req=%b required 1 0 0", nm, inst_valid, busy, imem_bus.imem_req);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_cmp++; if (inst !== exp) begin n_err++; $display("FAIL %s_inst: inst=%h required %h", nm, inst, exp); end
      last_inst = exp;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; fetch_start = 1'b0; pc_we = 1'b0; pc_src = 2'b00; imm16 = '0; addr26 = '0; jr_target = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = '0;
    tick; tick;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: pc=%h required 0", pc); end
    n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: inst=%h required 0", inst); end
    n_cmp++; if (inst_valid !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: valid=%b busy=%b err=%b required 0 0 0", inst_valid, busy, fetch_err);
    end
    n_cmp++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_bus: req=%b addr=%h required 0 0", imem_bus.imem_req, imem_bus.imem_addr);
    end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4: got %h required 4", pc_plus4); end
    RST = 1'b0;
  endtask

  task automatic test_fetch;
    do_fetch("basic", 32'h0, 32'h2001_0005, 0);
    do_fetch("stall3", 32'h0, 32'hAAAA_5555, 3);
    do_fetch("stall7_edge", 32'h0, 32'h1234_5678, 7);
  endtask

  task automatic test_pc_update;
    set_pc(32'h0000_0010);
    pc_we = 1'b1; pc_src = 2'b01; imm16 = 16'hFFFE; tick; pc_we = 1'b0;
    n_cmp++; if (pc !== 32'h0000_000C) begin n_err++; $display("FAIL branch_back: pc=%h required 0000000c", pc); end
    pc_we = 1'b1; pc_src = 2'b01; imm16 = 16'h0003; tick; pc_we = 1'b0;
    n_cmp++; if (pc !== 32'h0000_001C) begin n_err++; $display("FAIL branch_fwd: pc=%h required 0000001c", pc); end
    set_pc(32'h4000_0000);
    pc_we = 1'b1; pc_src = 2'b10; addr26 = 26'h0000040; tick; pc_we = 1'b0;
    n_cmp++; if (pc !== 32'h4000_0100) begin n_err++; $display("FAIL jump: pc=%h required 40000100", pc); end
    set_pc(32'hFFFF_FFFC);
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL plus4_wrap: pc_plus4=%h required 0", pc_plus4); end
    pc_we = 1'b1; pc_src = 2'b00; tick; pc_we = 1'b0;
    n_cmp++; if (pc !== 32'h0 || inst !== last_inst || inst_valid !== 1'b1) begin
      n_err++; $display("FAIL seq_wrap: pc=%h inst=%h valid=%b required 0 %h 1", pc, inst, inst_valid, last_inst);
    end
  endtask

  task automatic test_timeout;
    fetch_start = 1'b1; tick; fetch_start = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    n_cmp++; if (busy !== 1'b1 || fetch_err !== 1'b0) begin
      n_err++; $display("FAIL timeout_early: busy=%b err=%b required 1 0", busy, fetch_err);
    end
    tick;
    n_cmp++; if (fetch_err !== 1'b1 || imem_bus.imem_req !== 1'b0 || busy !== 1'b0 || inst_valid !== 1'b0 || inst !== last_inst) begin
      n_err++; $display("FAIL timeout: err=%b req=%b busy=%b valid=%b inst=%h required 1 0 0 0 %h", fetch_err, imem_bus.imem_req, busy, inst_valid, inst, last_inst);
    end
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hBAD0_BAD0;
    tick;
    imem_bus.imem_ready = 1'b0;
    n_cmp++; if (fetch_err !== 1'b0 || inst !== last_inst || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL timeout_after: err=%b inst=%h valid=%b required 0 %h 0", fetch_err, inst, inst_valid, last_inst);
    end
  endtask

  task automatic test_misaligned;
    int req_seen;
    set_pc(32'h0000_0006);
    req_seen = 0;
    fetch_start = 1'b1; tick; fetch_start = 1'b0;
    if (imem_bus.imem_req === 1'b1) req_seen++;
    n_cmp++; if (fetch_err !== 1'b1 || inst !== last_inst) begin
      n_err++; $display("FAIL misalign_err: err=%b inst=%h required 1 %h", fetch_err, inst, last_inst);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (imem_bus.imem_req === 1'b1) req_seen++;
    end
    n_cmp++; if (req_seen !== 0 || fetch_err !== 1'b0) begin
      n_err++; $display("FAIL misalign_req: req_cycles=%0d err=%b required 0 0", req_seen, fetch_err);
    end
  endtask

  task automatic test_back_to_back;
    int req_cycles;
    set_pc(32'h0000_0020);
    fetch_start = 1'b1; pc_we = 1'b1; pc_src = 2'b00;
    tick;
    pc_we = 1'b0;
    req_cycles = (imem_bus.imem_req === 1'b1) ? 1 : 0;
    n_cmp++; if (imem_bus.imem_addr !== 32'h20 || pc !== 32'h24) begin
      n_err++; $display("FAIL same_cycle: addr=%h pc=%h required 20 24", imem_bus.imem_addr, pc);
    end
    tick;
    fetch_start = 1'b0;
    if (imem_bus.imem_req === 1'b1) req_cycles++;
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'h0C00_0040;
    exp_q.push_back(32'h0C00_0040);
    tick;
    imem_bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (imem_bus.imem_req === 1'b1) req_cycles++;
      tick;
    end
    n_cmp++; if (req_cycles !== 2 || inst_valid !== 1'b1) begin
      n_err++; $display("FAIL busy_ignore: req_cycles=%0d valid=%b required 2 1", req_cycles, inst_valid);
    end
    if (exp_q.size() > 0) begin
      last_inst = exp_q.pop_front();
      n_cmp++; if (inst !== last_inst) begin n_err++; $display("FAIL b2b_inst: inst=%h required %h", inst, last_inst); end
    end
    do_fetch("from_hold", 32'h24, 32'h8C22_0004, 0);
  endtask

  task automatic test_reset_busy;
    fetch_start = 1'b1; tick; fetch_start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre: busy=%b required 1", busy); end
    RST = 1'b1; tick; RST = 1'b0;
    n_cmp++; if (imem_bus.imem_req !== 1'b0 || inst !== 32'h0 || pc !== 32'h0 || inst_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_busy: req=%b inst=%h pc=%h valid=%b busy=%b required 0 0 0 0 0", imem_bus.imem_req, inst, pc, inst_valid, busy);
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_left: entries=%0d required 0", exp_q.size()); end
  endtask

  initial begin
    last_inst = 32'h0;
    test_reset;
    test_fetch;
    test_pc_update;
    test_timeout;
    test_misaligned;
    test_back_to_back;
    test_reset_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
